decode: RTL and testbench
=========================

# decode

Instruction-decode stage of the 32-bit single-cycle/multi-cycle datapath. It holds the 32×32-bit register file and reads two operands from register fields of the current instruction. It writes back either the ALU result or the memory read data, and produces the 32-bit extended immediate for the current opcode. It sits between the fetch stage (supplies `Instr`) and the execute/memory stages (consume `RF_A`, `RF_B`, `Immed`; return `ALU_out`, `MEM_out`).

## Interface
- No parameters (32 registers × 32 bits fixed).
- Clock and reset: one clock; reset is asynchronous and active-high.
- `Clk` input 1 — single clock; register file writes on rising edge.
- `Reset` input 1 — asynchronous, active-high; clears the register file.
- `Instr` input 32 — current instruction.
- `ALU_out` input 32 — write-back candidate from the ALU.
- `MEM_out` input 32 — write-back candidate from data memory.
- `RF_WrEn` input 1 — register file write enable.
- `RF_WrData_sel` input 1 — write data select: 0 = `ALU_out`, 1 = `MEM_out`.
- `RF_B_sel` input 1 — second read address select: 0 = `Instr[15:11]`, 1 = `Instr[20:16]`.
- `RF_A` output 32 — contents of register `Instr[25:21]`.
- `RF_B` output 32 — contents of the register selected by `RF_B_sel`.
- `Immed` output 32 — extended immediate derived from `Instr[15:0]`.

## Operation
- Fields: opcode = `Instr[31:26]`, rs = `Instr[25:21]`, rd = `Instr[20:16]`, rt = `Instr[15:11]`, imm = `Instr[15:0]`.
- Read port A address = rs; read port B address = rt when `RF_B_sel`=0, rd when `RF_B_sel`=1.
- Write address is always rd. Write data = `RF_WrData_sel` ? `MEM_out` : `ALU_out`.
- Register 0 is hardwired to zero. Writes to r0 are ignored, and reads of r0 return 0.
- `Immed` depends on the opcode:
  - `111001` (lui): imm << 16, low 16 bits zero.
  - `110010` (andi), `110011` (ori): zero-extend imm.
  - `111111` (b), `000000` (beq), `000001` (bne): sign-extend imm, then shift left 2.
  - All other opcodes (li `111000`, addi `110000`, lb `000011`, lw `001111`, sb `000111`, sw `011111`, R-type `100000`, undefined): sign-extend imm.

## Timing
- Reads are combinational. `RF_A`, `RF_B` and `Immed` follow `Instr`, `RF_B_sel` and register contents with zero cycle latency.
- Write occurs at the rising edge of `Clk` when `RF_WrEn`=1 and `Reset`=0. The new value is visible on the read ports after that edge.
- Read and write to the same register in the same cycle: the read port shows the old value until the edge, then the new value. There is no internal bypass.
- `Reset`=1 asynchronously clears all 32 registers to 0. While reset is held, `RF_A` and `RF_B` read 0 and writes are blocked.
- Reset asserted mid-operation wins over a simultaneous write.
- `Immed` does not depend on reset.
- Outputs after reset: `RF_A` = `RF_B` = 0; `Immed` = function of `Instr` only.
- `RF_WrEn`=0 leaves the register file unchanged regardless of the other inputs.

## Test plan
- Reset pulse, then read any rs/rd/rt → `RF_A` = `RF_B` = 0x00000000. `Immed` for `Instr`=0xE0218002 = 0xFFFF8002.
- `RF_WrEn`=1, `RF_WrData_sel`=1, `MEM_out`=2, `Instr`=0xE0218002, one rising edge → r1 = 2. Then `RF_WrData_sel`=0, `ALU_out`=1, `Instr`=0xE0228002, one edge → r2 = 1. Then `RF_WrEn`=0, `RF_B_sel`=1, `Instr`=0xE0228002 → `RF_A` = 2 (r1), `RF_B` = 1 (r2).
- `RF_B_sel` switch: with r1=2, r2=1, `Instr`=0x80220800 (rs=1, rd=2, rt=1): `RF_B_sel`=0 → `RF_B`=2; `RF_B_sel`=1 → `RF_B`=1.
- Write to r0: `Instr` rd=0, `RF_WrEn`=1, `ALU_out`=0xDEADBEEF, edge → reading r0 gives 0.
- Immediate modes with imm=0x8001:
  - lui → 0x80010000.
  - andi/ori → 0x00008001.
  - addi → 0xFFFF8001.
  - beq → 0xFFFE0004.
  - b with imm=0x0003 → 0x0000000C.
- Async reset mid-run: r1=2, assert `Reset` between edges → `RF_A` (rs=1) drops to 0 immediately without waiting for a clock edge. A write requested on the next edge while reset is held is discarded.

Source files
------------

// File: rtl/decode.sv
// Instruction-decode stage: 32x32 register file with two combinational read
// ports, ALU/memory write-back select, and opcode-dependent immediate extension.
module decode (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [31:0] Instr,
    input  logic [31:0] ALU_out,
    input  logic [31:0] MEM_out,
    input  logic        RF_WrEn,
    input  logic        RF_WrData_sel,
    input  logic        RF_B_sel,
    output logic [31:0] RF_A,
    output logic [31:0] RF_B,
    output logic [31:0] Immed
);
    localparam int unsigned DW = 32;
    localparam int unsigned AW = 5;
    localparam int unsigned NREG = 32;

    localparam logic [5:0] OP_LUI  = 6'b111001;
    localparam logic [5:0] OP_ANDI = 6'b110010;
    localparam logic [5:0] OP_ORI  = 6'b110011;
    localparam logic [5:0] OP_B    = 6'b111111;
    localparam logic [5:0] OP_BEQ  = 6'b000000;
    localparam logic [5:0] OP_BNE  = 6'b000001;

    logic [5:0]    opcode;
    logic [AW-1:0] rs;
    logic [AW-1:0] rd;
    logic [AW-1:0] rt;
    logic [15:0]   imm;
    logic [AW-1:0] addr_b;
    logic [DW-1:0] wr_data;
    logic [DW-1:0] imm_sext;
    logic [DW-1:0] regs [NREG];

    assign opcode  = Instr[31:26];
    assign rs      = Instr[25:21];
    assign rd      = Instr[20:16];
    assign rt      = Instr[15:11];
    assign imm     = Instr[15:0];
    assign addr_b  = RF_B_sel ? rd : rt;
    assign wr_data = RF_WrData_sel ? MEM_out : ALU_out;

    // Register file; r0 is never written so it stays zero after reset.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < int'(NREG); i++) begin
                regs[i] <= '0;
            end
        end else if (RF_WrEn && (rd != '0)) begin
            regs[rd] <= wr_data;
        end
    end

    // r0 reads are forced to zero independent of storage.
    assign RF_A = (rs == '0)     ? '0 : regs[rs];
    assign RF_B = (addr_b == '0) ? '0 : regs[addr_b];

    assign imm_sext = {{16{imm[15]}}, imm};

    always_comb begin
        Immed = imm_sext;
        case (opcode)
            OP_LUI:                  Immed = {imm, 16'h0000};
            OP_ANDI, OP_ORI:         Immed = {16'h0000, imm};
            OP_B, OP_BEQ, OP_BNE:    Immed = {imm_sext[DW-3:0], 2'b00};
            default:                 Immed = imm_sext;
        endcase
    end

endmodule

// File: tb/tb_decode.sv
// Directed bench for decode: expected values queued at stimulus time and
// popped/compared against the combinational outputs at sample points.
module tb_decode;
    logic        Clk;
    logic        Reset;
    logic [31:0] Instr;
    logic [31:0] ALU_out;
    logic [31:0] MEM_out;
    logic        RF_WrEn;
    logic        RF_WrData_sel;
    logic        RF_B_sel;
    logic [31:0] RF_A;
    logic [31:0] RF_B;
    logic [31:0] Immed;

    localparam int SRC_A = 0;
    localparam int SRC_B = 1;
    localparam int SRC_I = 2;

    typedef struct {
        string       tag;
        int          src;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    decode dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .Instr         (Instr),
        .ALU_out       (ALU_out),
        .MEM_out       (MEM_out),
        .RF_WrEn       (RF_WrEn),
        .RF_WrData_sel (RF_WrData_sel),
        .RF_B_sel      (RF_B_sel),
        .RF_A          (RF_A),
        .RF_B          (RF_B),
        .Immed         (Immed)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic push(input string tag, input int src, input logic [31:0] exp);
        exp_t e;
        e.tag = tag;
        e.src = src;
        e.exp = exp;
        sb.push_back(e);
    endtask

    // Drain the scoreboard against the outputs as they stand now.
    task automatic check_all();
        exp_t        e;
        logic [31:0] obs;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            obs = (e.src == SRC_A) ? RF_A : (e.src == SRC_B) ? RF_B : Immed;
            n_checks++;
            assert (obs === e.exp) else begin
                n_fail++;
                $error("FAIL %s: observed %h expected %h", e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic edge_step();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        Reset = 1'b1; Instr = 32'hE0218002; ALU_out = '0; MEM_out = '0;
        RF_WrEn = 1'b0; RF_WrData_sel = 1'b0; RF_B_sel = 1'b0;
        edge_step();
        edge_step();
        Reset = 1'b0;
        #1;
        push("reset_rf_a", SRC_A, 32'h0);
        push("reset_rf_b", SRC_B, 32'h0);
        push("reset_immed", SRC_I, 32'hFFFF8002);
        check_all();

        // r1 <= MEM_out = 2; check read-before-write shows old value.
        RF_WrEn = 1'b1; RF_WrData_sel = 1'b1; MEM_out = 32'd2; RF_B_sel = 1'b1;
        Instr = 32'hE0218002;
        #1;
        push("pre_write_r1_old", SRC_B, 32'h0);
        check_all();
        edge_step();
        push("post_write_r1", SRC_B, 32'd2);
        check_all();

        // r2 <= ALU_out = 1.
        RF_WrData_sel = 1'b0; ALU_out = 32'd1; Instr = 32'hE0228002;
        edge_step();
        RF_WrEn = 1'b0; RF_B_sel = 1'b1; Instr = 32'hE0228002;
        #1;
        push("read_r1_on_a", SRC_A, 32'd2);
        push("read_r2_on_b", SRC_B, 32'd1);
        check_all();

        // RF_B_sel steering with rs=1 rd=2 rt=1.
        Instr = 32'h80220800; RF_B_sel = 1'b0;
        #1;
        push("bsel0_rt", SRC_B, 32'd2);
        check_all();
        RF_B_sel = 1'b1;
        #1;
        push("bsel1_rd", SRC_B, 32'd1);
        check_all();

        // Write-enable low must not modify r2.
        RF_WrEn = 1'b0; ALU_out = 32'h12345678; RF_WrData_sel = 1'b0;
        edge_step();
        push("wren0_hold", SRC_B, 32'd1);
        check_all();

        // Write to r0 ignored.
        Instr = 32'h80000000; RF_WrEn = 1'b1; ALU_out = 32'hDEADBEEF;
        edge_step();
        RF_WrEn = 1'b0;
        #1;
        push("r0_a", SRC_A, 32'h0);
        push("r0_b", SRC_B, 32'h0);
        check_all();

        // Write to r31 with full value, read on both ports.
        Instr = 32'h03FF0000; RF_WrEn = 1'b1; ALU_out = 32'hA5A5_5A5A; RF_B_sel = 1'b1;
        edge_step();
        RF_WrEn = 1'b0;
        #1;
        push("r31_a", SRC_A, 32'hA5A55A5A);
        push("r31_b", SRC_B, 32'hA5A55A5A);
        check_all();

        // Immediate modes.
        Instr = 32'hE4008001; #1; push("imm_lui",  SRC_I, 32'h80010000); check_all();
        Instr = 32'hC8008001; #1; push("imm_andi", SRC_I, 32'h00008001); check_all();
        Instr = 32'hCC008001; #1; push("imm_ori",  SRC_I, 32'h00008001); check_all();
        Instr = 32'hC0008001; #1; push("imm_addi", SRC_I, 32'hFFFF8001); check_all();
        Instr = 32'h00008001; #1; push("imm_beq",  SRC_I, 32'hFFFE0004); check_all();
        Instr = 32'h04008001; #1; push("imm_bne",  SRC_I, 32'hFFFE0004); check_all();
        Instr = 32'hFC000003; #1; push("imm_b",    SRC_I, 32'h0000000C); check_all();
        Instr = 32'h3C008001; #1; push("imm_lw",   SRC_I, 32'hFFFF8001); check_all();
        Instr = 32'hE4007FFF; #1; push("imm_lui_pos", SRC_I, 32'h7FFF0000); check_all();

        // Async reset between edges clears r1 immediately.
        Instr = 32'hE0218002; RF_B_sel = 1'b1;
        #1;
        push("pre_reset_r1", SRC_A, 32'd2);
        check_all();
        @(negedge Clk);
        Reset = 1'b1;
        #1;
        push("async_reset_a", SRC_A, 32'h0);
        push("reset_immed_indep", SRC_I, 32'hFFFF8002);
        check_all();
        RF_WrEn = 1'b1; RF_WrData_sel = 1'b1; MEM_out = 32'h0000_0077;
        edge_step();
        push("write_blocked_in_reset", SRC_B, 32'h0);
        check_all();
        RF_WrEn = 1'b0;
        Reset = 1'b0;
        #1;
        push("after_reset_r1", SRC_A, 32'h0);
        push("after_reset_r1_b", SRC_B, 32'h0);
        check_all();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
